// File: rtl/cache_valid_table_pkg.sv
// Shared definitions for the cache valid table and the tag/data arrays beside it.
// Sweep FSM state encoding, default geometry, and a width helper.
package cache_valid_table_pkg;

    localparam int CACHE_SETS_DEF = 64;
    localparam int CACHE_WAYS_DEF = 2;

    typedef enum logic {
        VT_IDLE  = 1'b0,
        VT_SWEEP = 1'b1
    } vt_state_e;

    // A direct-mapped cache still needs a 1-bit way field on the ports.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Refill victim selection: lowest invalid way, else a round-robin pointer
// that only advances when a fully valid set is read.
module cache_victim_sel
    import cache_valid_table_pkg::*;
#(
    parameter  int WAYS  = CACHE_WAYS_DEF,
    localparam int WAY_W = clog2_min1(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WAYS-1:0]  set_bits,
    input  logic             adv_en,
    output logic [WAY_W-1:0] victim_o
);

    logic [WAY_W-1:0] rr_ptr_q;
    logic [WAY_W-1:0] rr_ptr_d;

    always_comb begin
        victim_o = rr_ptr_q;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!set_bits[i]) begin
                victim_o = WAY_W'(i);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (adv_en && (&set_bits)) begin
            rr_ptr_d = (rr_ptr_q == WAY_W'(WAYS - 1)) ? '0 : rr_ptr_q + WAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/cache_valid_table.sv
// SETS x WAYS valid-bit table with registered write-first read, victim pick
// and a one-set-per-cycle fence.i sweep. Optional dirty bits: CACHE_VT_DIRTY_EN.
module cache_valid_table
    import cache_valid_table_pkg::*;
#(
    parameter  int SETS  = CACHE_SETS_DEF,
    parameter  int WAYS  = CACHE_WAYS_DEF,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = clog2_min1(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAYS-1:0]  rd_valid_o,
    output logic [WAY_W-1:0] rd_victim_o,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WAY_W-1:0] wr_way,
    input  logic             wr_v,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done
`ifdef CACHE_VT_DIRTY_EN
    ,
    input  logic             wr_d,
    output logic [WAYS-1:0]  rd_dirty_o
`endif
);

    vt_state_e        state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             flush_busy_q;
    logic             flush_done_q;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [WAYS-1:0]  rd_valid_q, rd_valid_d;
    logic [WAY_W-1:0] rd_victim_q, rd_victim_d;
    logic [WAYS-1:0]  rd_bits;
    logic [WAY_W-1:0] victim;
    logic             sweeping;

    assign sweeping = (state_q == VT_SWEEP);

    // Writes are dropped while sweeping; the sweep clears one whole set per cycle.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            valid_d[s] = valid_q[s];
        end
        if (sweeping) begin
            valid_d[cnt_q] = '0;
        end else if (wr_en) begin
            valid_d[wr_idx][wr_way] = wr_v;
        end
    end

    // Reading the next-state array gives write-first bypass on a collision.
    assign rd_bits = valid_d[rd_idx];

    cache_victim_sel #(
        .WAYS(WAYS)
    ) u_victim_sel (
        .clk      (clk),
        .reset    (reset),
        .set_bits (rd_bits),
        .adv_en   (rd_en && !sweeping),
        .victim_o (victim)
    );

    always_comb begin
        rd_valid_d  = rd_valid_q;
        rd_victim_d = rd_victim_q;
        if (rd_en) begin
            rd_valid_d  = sweeping ? '0 : rd_bits;
            rd_victim_d = sweeping ? '0 : victim;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
            rd_valid_q  <= '0;
            rd_victim_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_valid_q  <= rd_valid_d;
            rd_victim_q <= rd_victim_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= VT_IDLE;
            cnt_q        <= '0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                VT_IDLE: begin
                    if (flush_req) begin
                        state_q      <= VT_SWEEP;
                        flush_busy_q <= 1'b1;
                    end
                end
                VT_SWEEP: begin
                    if (cnt_q == IDX_W'(SETS - 1)) begin
                        state_q      <= VT_IDLE;
                        flush_busy_q <= 1'b0;
                        flush_done_q <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: state_q <= VT_IDLE;
            endcase
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_victim_o = rd_victim_q;
    assign flush_busy  = flush_busy_q;
    assign flush_done  = flush_done_q;

`ifdef CACHE_VT_DIRTY_EN
    // Dirty bits mirror the valid array's write, sweep and bypass behaviour.
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-1:0] dirty_d [SETS];
    logic [WAYS-1:0] rd_dirty_q, rd_dirty_d;

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            dirty_d[s] = dirty_q[s];
        end
        if (sweeping) begin
            dirty_d[cnt_q] = '0;
        end else if (wr_en) begin
            dirty_d[wr_idx][wr_way] = wr_d;
        end
    end

    always_comb begin
        rd_dirty_d = rd_dirty_q;
        if (rd_en) begin
            rd_dirty_d = sweeping ? '0 : dirty_d[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                dirty_q[s] <= '0;
            end
            rd_dirty_q <= '0;
        end else begin
            dirty_q    <= dirty_d;
            rd_dirty_q <= rd_dirty_d;
        end
    end

    assign rd_dirty_o = rd_dirty_q;
`endif

endmodule

// File: doc/cache_valid_table.md
Name: cache_valid_table

Overview:
- Parametrised valid-bit table for the set-associative I/D caches. Successor to the single-way 64-entry valid table.
- Holds SETS x WAYS valid bits with a registered read, and selects a refill victim per read.
- Provides a sequential flush sweep for fence.i, one set per cycle.
- Sits beside the tag/data SRAMs. The cache controller FSM drives it.

Parameters:
- SETS, 64: number of sets; power of two, >= 2.
- WAYS, 2: associativity; power of two, >= 1.
- IDX_W, $clog2(SETS): set index width (derived).
- WAY_W, max(1,$clog2(WAYS)): way index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_en  in  1  read request
- rd_idx  in  IDX_W  set to read
- rd_valid_o  out  WAYS  valid bits of the set read (registered)
- rd_victim_o  out  WAY_W  way to refill (registered)
- wr_en  in  1  write one valid bit
- wr_idx  in  IDX_W  set to write
- wr_way  in  WAY_W  way to write
- wr_v  in  1  valid value to write
- flush_req  in  1  start invalidate sweep (level sampled in IDLE)
- flush_busy  out  1  sweep in progress
- flush_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset, synchronous, active-high, clock clk:
  - All SETS*WAYS valid bits clear in one cycle.
  - rd_valid_o=0, rd_victim_o=0, flush_busy=0, flush_done=0.
  - FSM goes to IDLE; sweep counter and round-robin pointer go to 0.
  - Reset mid-sweep aborts the sweep with no flush_done pulse.
- Read:
  - Latency is 1 cycle: outputs update at the edge where rd_en=1.
  - With rd_en=0, rd_valid_o and rd_victim_o hold their values.
- Write:
  - Takes effect at the edge where wr_en=1. Only valid[wr_idx][wr_way] changes.
- Read/write collision (rd_en && wr_en && rd_idx==wr_idx, same cycle):
  - Write-first: rd_valid_o shows the post-write bits.
  - The victim is computed from the post-write bits.
- Victim selection (from the post-write set bits):
  - If any way is invalid, pick the lowest-index invalid way.
  - Otherwise pick rr_ptr, then rr_ptr <= rr_ptr+1 mod WAYS.
  - rr_ptr changes only on a read of a fully valid set.
  - WAYS=1: victim is always 0.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP when flush_req=1.
  - In SWEEP, each cycle clears all ways of set cnt, then cnt++.
  - When cnt==SETS-1 is cleared: go to IDLE, assert flush_done for the next cycle, reset cnt to 0.
  - A sweep takes exactly SETS cycles.
  - flush_busy=1 exactly while in SWEEP (registered).
- During SWEEP:
  - wr_en is ignored (dropped). The controller must stall refills.
  - Reads are accepted but rd_valid_o is forced to 0 and the victim is forced to 0; rr_ptr does not change.
  - flush_req is ignored.
- flush_req held high at the completion cycle: a new sweep starts the cycle after flush_done; the IDLE cycle samples it.

Optional Feature:
- Macro CACHE_VT_DIRTY_EN.
- When defined, the block adds:
  - Ports wr_d (in, 1) and rd_dirty_o (out, WAYS).
  - A parallel dirty array written together with valid.
  - The same write-first bypass for dirty bits.
  - Reset and sweep clear the dirty bits.
  - A victim-dirty indication: rd_dirty_o[rd_victim_o] is usable by the D-cache writeback.
- When undefined: no dirty storage and no ports; behaviour is as above.

Decomposition:
- Shared package holds:
  - FSM state enum (VT_IDLE, VT_SWEEP).
  - Function clog2_min1 for WAY_W.
  - Defaults CACHE_SETS_DEF=64 and CACHE_WAYS_DEF=2, shared with the tag/data arrays.
- One natural sub-module: cache_victim_sel.
  - Combinational priority encoder for the lowest invalid way, plus the round-robin pointer register.
  - Parametrised by WAYS.

Test Plan:
- Reset, then rd_en at idx 5 -> next cycle rd_valid_o=2'b00, victim=0.
- Write way1 of idx 3 (v=1), read idx 3 the next cycle -> valid=2'b10, victim=0. Write way0 too, then read -> valid=2'b11, victim=0. Read again -> victim=1, then 0 (round-robin).
- Same-cycle wr_en idx 7 way0 v=1 with rd_en idx 7 -> next cycle rd_valid_o=2'b01, victim=1 (bypass).
- Fill all sets, then flush_req pulse -> flush_busy high for exactly 64 cycles, flush_done for 1 cycle; a read of any set afterwards returns 0. Writes during the sweep are not retained.
- Assert reset at cycle 10 of a sweep -> flush_busy=0 next cycle, no flush_done, all valid=0. A following flush_req restarts from set 0.
- With CACHE_VT_DIRTY_EN: write idx 2 way1 v=1 d=1, read -> rd_dirty_o=2'b10. After a sweep, rd_dirty_o=0.
